// File: rtl/lsu_ctrl.sv
// Load/store unit controller: sequences single-word data-memory accesses for the pipeline,
// including read-modify-write for byte/halfword stores and sign/zero extension for loads.
module lsu_ctrl #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [DATA_W-1:0]     store_data,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     load_data,
    output logic                  access_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wd,
    input  logic [DATA_W-1:0]     mem_rd
);

    // state  | meaning
    // IDLE   | ready for a request
    // LOAD   | mem_read asserted, load word captured at cycle end
    // WRITE  | mem_write asserted with the full store word
    // RMW_RD | mem_read asserted, word captured and merged
    // RMW_WR | mem_write asserted with the merged word
    // RESP   | resp_valid pulse, results presented
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP} state_t;

    state_t            state;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [15:0]       sd_q;
    logic              rd_q;
    logic              wr_q;
    logic              req_err;
    logic [4:0]        b_lsb;
    logic [4:0]        h_lsb;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] merged;
    logic              unused_addr;

    assign unused_addr = ^addr[31:DM_ADDRESS+2];

    // Strobes are gated by reset so an in-flight write never lands on the reset edge.
    assign mem_read  = rd_q & ~reset;
    assign mem_write = wr_q & ~reset;

    always_comb begin
        req_err = 1'b0;
        if (req_we)
            req_err = funct3[2] | (funct3[1:0] == 2'b11);
        else
            req_err = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        if ((funct3[1:0] == 2'b01) && addr[0])
            req_err = 1'b1;
        if ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00))
            req_err = 1'b1;
    end

    assign b_lsb    = {off_q, 3'b000};
    assign h_lsb    = {off_q[1], 4'b0000};
    assign byte_sel = mem_rd[b_lsb +: 8];
    assign half_sel = mem_rd[h_lsb +: 16];

    always_comb begin
        load_ext = mem_rd;
        case (f3_q)
            3'b000:  load_ext = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{(DATA_W-16){half_sel[15]}}, half_sel};
            3'b100:  load_ext = {{(DATA_W-8){1'b0}}, byte_sel};
            3'b101:  load_ext = {{(DATA_W-16){1'b0}}, half_sel};
            default: load_ext = mem_rd;
        endcase
    end

    always_comb begin
        merged = mem_rd;
        if (f3_q[1:0] == 2'b00)
            merged[b_lsb +: 8] = sd_q[7:0];
        else
            merged[h_lsb +: 16] = sd_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            load_data  <= '0;
            access_err <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            mem_addr   <= '0;
            mem_wd     <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            sd_q       <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        f3_q      <= funct3;
                        off_q     <= addr[1:0];
                        sd_q      <= store_data[15:0];
                        mem_addr  <= addr[DM_ADDRESS+1:2];
                        req_ready <= 1'b0;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            access_err <= 1'b1;
                            load_data  <= '0;
                        end else if (!req_we) begin
                            state <= LOAD;
                            rd_q  <= 1'b1;
                        end else if (funct3[1:0] == 2'b10) begin
                            state  <= WRITE;
                            wr_q   <= 1'b1;
                            mem_wd <= store_data;
                        end else begin
                            state <= RMW_RD;
                            rd_q  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    rd_q       <= 1'b0;
                    load_data  <= load_ext;
                    access_err <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                WRITE, RMW_WR: begin
                    wr_q       <= 1'b0;
                    load_data  <= '0;
                    access_err <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RMW_RD: begin
                    rd_q   <= 1'b0;
                    wr_q   <= 1'b1;
                    mem_wd <= merged;
                    state  <= RMW_WR;
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    rd_q      <= 1'b0;
                    wr_q      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural data memory and strobe/address monitors.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        access_err;
    logic        mem_read;
    logic        mem_write;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:511];
    logic        poke_en = 1'b0;
    logic [8:0]  poke_a = '0;
    logic [31:0] poke_d = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int addr_bad = 0;
    int both_bad = 0;
    logic       mon_en = 1'b0;
    logic [8:0] exp_word = '0;

    lsu_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .funct3(funct3), .addr(addr), .store_data(store_data),
        .resp_valid(resp_valid), .load_data(load_data), .access_err(access_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_write)
            mem[mem_addr] <= mem_wd;
        else if (poke_en)
            mem[poke_a] <= poke_d;
    end

    always @(posedge clk) begin
        if (mem_read) rd_cnt <= rd_cnt + 1;
        if (mem_write) wr_cnt <= wr_cnt + 1;
        if (mem_read && mem_write) both_bad <= both_bad + 1;
        if (mon_en && (mem_read || mem_write) && (mem_addr != exp_word)) addr_bad <= addr_bad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [8:0] a, input logic [31:0] d);
        poke_en = 1'b1;
        poke_a  = a;
        poke_d  = d;
        step();
        poke_en = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input int exp_lat,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int exp_rd, input int exp_wr);
        int lat;
        int rd0;
        int wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        exp_word   = a[10:2];
        mon_en     = 1'b1;
        req_we     = we;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        req_valid  = 1'b1;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, load_data, exp_data);
        chk({tag, "_err"}, 32'(access_err), 32'(exp_err));
        step();
        chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
        chk({tag, "_hold"}, load_data, exp_data);
        chk({tag, "_nrd"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        chk({tag, "_nwr"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        mon_en = 1'b0;
    endtask

    logic [31:0] b2b_exp [0:2];

    initial begin
        int rd0;
        int wr0;
        int nacc;
        int nresp;
        logic was_ready;

        reset = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        funct3 = 3'b000;
        addr = '0;
        store_data = '0;
        poke(9'd0, 32'h55AA_55AA);
        poke(9'd2, 32'hCAFE_0000);
        poke(9'd3, 32'h1122_3344);
        poke(9'd5, 32'h8000_00F0);
        poke(9'd8, 32'h0000_0000);
        poke(9'd10, 32'h0000_0A01);
        poke(9'd11, 32'h0000_0B02);
        poke(9'd12, 32'h0000_0C03);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        reset = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_access_err", 32'(access_err), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);

        do_req("lb",   1'b0, 3'b000, 32'h14, 32'h0, 2, 32'hFFFF_FFF0, 1'b0, 1, 0);
        do_req("lbu",  1'b0, 3'b100, 32'h14, 32'h0, 2, 32'h0000_00F0, 1'b0, 1, 0);
        do_req("lh",   1'b0, 3'b001, 32'h16, 32'h0, 2, 32'hFFFF_8000, 1'b0, 1, 0);
        do_req("lhu",  1'b0, 3'b101, 32'h16, 32'h0, 2, 32'h0000_8000, 1'b0, 1, 0);
        do_req("sb",   1'b1, 3'b000, 32'h0D, 32'h0000_00AB, 3, 32'h0, 1'b0, 1, 1);
        chk("sb_mem", mem[3], 32'h1122_AB44);
        do_req("sw",   1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 0, 1);
        chk("sw_mem", mem[8], 32'hDEAD_BEEF);
        do_req("lw",   1'b0, 3'b010, 32'h20, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 1, 0);
        do_req("lw_mis", 1'b0, 3'b010, 32'h22, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        do_req("sh_mis", 1'b1, 3'b001, 32'h01, 32'hFFFF_FFFF, 1, 32'h0, 1'b1, 0, 0);
        chk("sh_mis_mem", mem[0], 32'h55AA_55AA);
        do_req("ld_ill", 1'b0, 3'b011, 32'h00, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        do_req("sh_hi", 1'b1, 3'b001, 32'h0E, 32'h1234_5678, 3, 32'h0, 1'b0, 1, 1);
        chk("sh_hi_mem", mem[3], 32'h5678_AB44);
        do_req("lb_b3", 1'b0, 3'b000, 32'h0F, 32'h0, 2, 32'h0000_0056, 1'b0, 1, 0);

        // Back-to-back loads with req_valid held high.
        b2b_exp[0] = 32'h0000_0A01;
        b2b_exp[1] = 32'h0000_0B02;
        b2b_exp[2] = 32'h0000_0C03;
        nacc = 0;
        nresp = 0;
        req_we = 1'b0;
        funct3 = 3'b010;
        addr = 32'h28;
        req_valid = 1'b1;
        for (int c = 0; c < 30 && nresp < 3; c++) begin
            was_ready = req_ready;
            step();
            if (was_ready && req_valid) begin
                nacc++;
                if (nacc < 3) addr = 32'h28 + 32'(nacc * 4);
                else req_valid = 1'b0;
            end
            if (resp_valid) begin
                if (nresp < 3) chk("b2b_data", load_data, b2b_exp[nresp]);
                nresp++;
            end
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(nacc), 32'd3);
        chk("b2b_resps", 32'(nresp), 32'd3);
        step();
        step();

        // Reset arriving in the RMW_RD cycle of a halfword store.
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        req_we = 1'b1;
        funct3 = 3'b001;
        addr = 32'h08;
        store_data = 32'h0000_1234;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("rst_rmw_rd_strobe", 32'(mem_read), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_rmw_force_rd", 32'(mem_read), 32'd0);
        chk("rst_rmw_force_wr", 32'(mem_write), 32'd0);
        step();
        reset = 1'b0;
        step();
        step();
        chk("rst_rmw_nwr", 32'(wr_cnt - wr0), 32'd0);
        chk("rst_rmw_mem", mem[2], 32'hCAFE_0000);
        chk("rst_rmw_idle", 32'(req_ready), 32'd1);
        chk("rst_rmw_resp", 32'(resp_valid), 32'd0);
        chk("rst_rmw_addr", 32'(mem_addr), 32'd0);
        chk("rst_rmw_nrd", 32'(rd_cnt - rd0), 32'd0);

        chk("addr_stable", 32'(addr_bad), 32'd0);
        chk("rd_wr_overlap", 32'(both_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, word-address width of the data memory port.
REQ-002 SHALL have parameter DATA_W, default 32, data width of pipeline and memory ports.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1, pipeline presents a memory request.
REQ-006 SHALL have port req_ready, output, 1, block accepts a request this cycle.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port funct3, input, 3, RISC-V access size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 SHALL have port addr, input, 32, byte address from the ALU.
REQ-010 SHALL have port store_data, input, DATA_W, rs2 value for stores.
REQ-011 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port load_data, output, DATA_W, extended load result, valid with resp_valid.
REQ-013 SHALL have port access_err, output, 1, misaligned or illegal access, valid with resp_valid.
REQ-014 SHALL have port mem_read, output, 1, read strobe to data memory.
REQ-015 SHALL have port mem_write, output, 1, write strobe to data memory; memory writes on the clk edge.
REQ-016 SHALL have port mem_addr, output, DM_ADDRESS, word address = addr[DM_ADDRESS+1:2].
REQ-017 SHALL have port mem_wd, output, DATA_W, full word written to memory.
REQ-018 SHALL have port mem_rd, input, DATA_W, combinational read data from memory, valid while mem_read = 1.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP.
REQ-020 SHALL assert req_ready = 1 only in IDLE; a request is accepted on a clk edge with req_valid & req_ready, latching req_we, funct3, addr and store_data.
REQ-021 SHALL classify an access as an error when funct3 is illegal (load: 011, 110, 111; store: any value other than 000/001/010), when a halfword has addr[0] = 1, or when a word has addr[1:0] != 00.
REQ-022 SHALL go IDLE -> RESP on an error access, with access_err = 1, load_data = 0 and no memory strobe.
REQ-023 SHALL go IDLE -> LOAD on a legal load; in LOAD assert mem_read, capture mem_rd, then go to RESP (resp_valid 2 cycles after accept).
REQ-024 SHALL go IDLE -> WRITE on SW; in WRITE assert mem_write with mem_wd = store_data, then go to RESP (2 cycles).
REQ-025 SHALL go IDLE -> RMW_RD on SB/SH; in RMW_RD assert mem_read and capture the word; in RMW_WR assert mem_write with the merged word; then go to RESP (3 cycles).
REQ-026 SHALL form the merge by replacing only byte addr[1:0] (SB, store_data[7:0]) or half addr[1] (SH, store_data[15:0]), leaving all other bytes unchanged.
REQ-027 SHALL extract loads by byte lane addr[1:0] or half lane addr[1]: LB/LH sign-extend, LBU/LHU zero-extend, LW pass through.
REQ-028 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; load_data = 0 on stores; load_data and access_err hold until the next RESP.
REQ-029 SHALL keep mem_read = 0 outside LOAD/RMW_RD, keep mem_write = 0 outside WRITE/RMW_WR, and never assert both in the same cycle.
REQ-030 SHALL hold mem_addr stable for the whole transaction, including both RMW cycles.
REQ-031 SHALL ignore req_valid while not in IDLE; back-to-back requests are accepted in the IDLE cycle after RESP.

Reset
REQ-032 SHALL, while reset = 1, force mem_read = 0 and mem_write = 0 combinationally, so that no memory write occurs on the edge where reset is sampled.
REQ-033 SHALL, on a clk edge with reset = 1, enter IDLE, aborting any in-flight transaction without a memory write.
REQ-034 SHALL, after reset, drive resp_valid = 0, access_err = 0, load_data = 0, mem_addr = 0 and mem_wd = 0; req_ready = 1 in the first cycle after reset deasserts.

Verification
REQ-035 SHALL cover: mem word 5 = 0x8000_00F0; LB addr 0x14 -> resp 2 cycles after accept, load_data 0xFFFF_FFF0; LBU -> 0x0000_00F0; LH addr 0x16 -> 0xFFFF_8000.
REQ-036 SHALL cover: word 3 = 0x1122_3344; SB addr 0x0D, data 0xAB -> RMW_RD then RMW_WR, memory 0x1122_AB44, resp 3 cycles after accept.
REQ-037 SHALL cover: SW addr 0x20, data 0xDEAD_BEEF -> one mem_write cycle at word 8; a following LW returns 0xDEAD_BEEF.
REQ-038 SHALL cover: LW addr 0x22 and SH addr 0x01 -> resp 1 cycle after accept, access_err = 1, no strobe, memory unchanged.
REQ-039 SHALL cover: reset asserted in the RMW_RD cycle of SH to word 2 (0xCAFE_0000) -> no mem_write, word 2 still 0xCAFE_0000, FSM in IDLE.
REQ-040 SHALL cover: req_valid held high across 3 loads -> each accepted only in IDLE, exactly one resp_valid per request, in order.
